// File: rtl/sram_like_mem_responder_if.sv
// rtl/sram_like_mem_responder_if.sv - sram-like request/response handshake between CPU-side master and memory responder
interface sram_like_mem_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_mem_responder.sv
// rtl/sram_like_mem_responder.sv - sram-like responder backed by a byte-lane word array, fixed plus optional LFSR latency
module sram_like_mem_responder #(
    parameter int          ADDR_W     = 10,
    parameter int          LATENCY    = 2,
    parameter int          RAND_DELAY = 0,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic                        clk,
    input  logic                        rst,
    sram_like_mem_responder_if.slave    bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam int         CNT_W  = $clog2(LATENCY + 3) + 1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] widx;
    logic [3:0]        wmask;
    logic [1:0]        extra;
    logic [CNT_W-1:0]  load_val;
    logic              addr_ok_int;
    logic              accept;
    logic              lfsr_fb;

    assign widx        = bus.addr[ADDR_W+1:2];
    assign addr_ok_int = ~rst & (state_q != S_WAIT);
    assign accept      = bus.req & addr_ok_int;
    assign extra       = (RAND_DELAY != 0) ? lfsr_q[1:0] : 2'd0;
    assign load_val    = CNT_W'(LATENCY - 1) + CNT_W'(extra);
    assign lfsr_fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    assign bus.addr_ok = addr_ok_int;
    assign bus.data_ok = ~rst & (state_q == S_RESP);
    assign bus.rdata   = bus.data_ok ? rdata_q : 32'h0;

    // Misaligned and reserved sizes yield an empty mask but still complete.
    always_comb begin
        wmask = 4'b0000;
        case (bus.size)
            2'd0: wmask = 4'b0001 << bus.addr[1:0];
            2'd1: begin
                if (bus.addr[1:0] == 2'b00)      wmask = 4'b0011;
                else if (bus.addr[1:0] == 2'b10) wmask = 4'b1100;
                else                             wmask = 4'b0000;
            end
            2'd2: wmask = (bus.addr[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
            default: wmask = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        rdata_d = rdata_q;
        if (accept) begin
            cnt_d   = load_val;
            lfsr_d  = {lfsr_q[6:0], lfsr_fb};
            rdata_d = mem[widx];
            state_d = (load_val == '0) ? S_RESP : S_WAIT;
        end else begin
            case (state_q)
                // Leave WAIT on the edge where the counter reaches zero, so data_ok lands L+E cycles after acceptance.
                S_WAIT: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_RESP;
                        cnt_d   = '0;
                    end
                end
                S_RESP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is not reset; the write uses the same acceptance qualifier as the read latch.
    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_like_mem_responder.sv
// tb/tb_sram_like_mem_responder.sv - self-checking bench for sram_like_mem_responder
module tb_sram_like_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    int          sel;
    logic        aok, dok;
    logic [31:0] rdm;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sram_like_mem_responder_if if_a ();
    sram_like_mem_responder_if if_b ();
    sram_like_mem_responder_if if_c ();
    sram_like_mem_responder_if if_d ();

    assign if_a.req = req & (sel == 0);
    assign if_b.req = req & (sel == 1);
    assign if_c.req = req & (sel == 2);
    assign if_d.req = req & (sel == 3);
    assign if_a.wr = wr;  assign if_a.size = size;  assign if_a.addr = addr;  assign if_a.wdata = wdata;
    assign if_b.wr = wr;  assign if_b.size = size;  assign if_b.addr = addr;  assign if_b.wdata = wdata;
    assign if_c.wr = wr;  assign if_c.size = size;  assign if_c.addr = addr;  assign if_c.wdata = wdata;
    assign if_d.wr = wr;  assign if_d.size = size;  assign if_d.addr = addr;  assign if_d.wdata = wdata;

    always_comb begin
        aok = if_a.addr_ok; dok = if_a.data_ok; rdm = if_a.rdata;
        case (sel)
            1: begin aok = if_b.addr_ok; dok = if_b.data_ok; rdm = if_b.rdata; end
            2: begin aok = if_c.addr_ok; dok = if_c.data_ok; rdm = if_c.rdata; end
            3: begin aok = if_d.addr_ok; dok = if_d.data_ok; rdm = if_d.rdata; end
            default: ;
        endcase
    end

    sram_like_mem_responder #(.ADDR_W(10), .LATENCY(2), .RAND_DELAY(0), .LFSR_SEED(8'hA5))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    sram_like_mem_responder #(.ADDR_W(10), .LATENCY(1), .RAND_DELAY(0), .LFSR_SEED(8'hA5))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    sram_like_mem_responder #(.ADDR_W(10), .LATENCY(2), .RAND_DELAY(1), .LFSR_SEED(8'hA5))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));
    sram_like_mem_responder #(.ADDR_W(10), .LATENCY(4), .RAND_DELAY(0), .LFSR_SEED(8'hA5))
        dut_d (.clk(clk), .rst(rst), .bus(if_d));

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        chk_rd;
    } vec_t;

    vec_t        vec [14];
    logic [31:0] model [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'd0:    return 4'b0001 << a;
            2'd1:    return (a == 2'd0) ? 4'b0011 : ((a == 2'd2) ? 4'b1100 : 4'b0000);
            2'd2:    return (a == 2'd0) ? 4'b1111 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    // One complete transaction; lat counts cycles from the accepting edge to the data_ok cycle.
    task automatic txn(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        req = 1'b1; wr = w; size = sz; addr = a; wdata = wd;
        while (!aok && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL accept_timeout: addr_ok never seen for addr %h", a);
        end
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (!dok && lat < 20) begin @(negedge clk); lat++; end
        rd = rdm;
        if (lat >= 20) begin
            checks++; errors++;
            $display("FAIL data_ok_timeout: no data_ok for addr %h", a);
        end
        @(negedge clk);
        chk("single_pulse", {31'b0, dok}, 32'h0);
    endtask

    // Accept one request on the selected L=4 responder, then reset it while it waits.
    task automatic abandon(input logic w, input logic [31:0] a, input logic [31:0] wd);
        int pulses;
        @(negedge clk);
        req = 1'b1; wr = w; size = 2'd2; addr = a; wdata = wd;
        chk("abandon_aok_idle", {31'b0, aok}, 32'h1);
        @(negedge clk);
        req = 1'b0;
        chk("abandon_aok_wait", {31'b0, aok}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) chk("abandon_aok_after_rst", {31'b0, aok}, 32'h1);
            if (dok) pulses++;
        end
        chk("abandon_no_data_ok", pulses, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        logic [31:0] exp_b [4];
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0; sel = 0;

        vec[0]  = '{1'b1, 2'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
        vec[1]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b1};
        vec[2]  = '{1'b1, 2'd0, 32'h11,   32'h00007700, 32'hDEADBEEF, 1'b1};
        vec[3]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'hDEAD77EF, 1'b1};
        vec[4]  = '{1'b1, 2'd1, 32'h12,   32'h12340000, 32'hDEAD77EF, 1'b1};
        vec[5]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'h123477EF, 1'b1};
        vec[6]  = '{1'b1, 2'd1, 32'h13,   32'hFFFFFFFF, 32'h123477EF, 1'b1};
        vec[7]  = '{1'b1, 2'd2, 32'h12,   32'hFFFFFFFF, 32'h123477EF, 1'b1};
        vec[8]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'h123477EF, 1'b1};
        vec[9]  = '{1'b1, 2'd3, 32'h10,   32'h00000000, 32'h123477EF, 1'b1};
        vec[10] = '{1'b1, 2'd2, 32'h1010, 32'hAAAAAAAA, 32'h123477EF, 1'b1};
        vec[11] = '{1'b0, 2'd2, 32'h10,   32'h0,        32'hAAAAAAAA, 1'b1};
        vec[12] = '{1'b1, 2'd0, 32'h13,   32'h55000000, 32'hAAAAAAAA, 1'b1};
        vec[13] = '{1'b0, 2'd0, 32'h12,   32'h0,        32'h55AAAAAA, 1'b1};

        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            chk("rst_addr_ok", {31'b0, aok}, 32'h0);
            chk("rst_data_ok", {31'b0, dok}, 32'h0);
            chk("rst_rdata", rdm, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            chk("post_rst_addr_ok", {31'b0, aok}, 32'h1);
            chk("post_rst_data_ok", {31'b0, dok}, 32'h0);
        end

        sel = 0;
        for (int i = 0; i < 14; i++) begin
            txn(vec[i].w, vec[i].sz, vec[i].a, vec[i].wd, rd, lat);
            chk($sformatf("vec%0d_latency", i), lat, 2);
            if (vec[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vec[i].exp);
        end

        sel = 1;
        for (int i = 0; i < 4; i++) begin
            exp_b[i] = 32'h1111_0000 + 32'(i * 32'h0101);
            txn(1'b1, 2'd2, 32'(i * 4), exp_b[i], rd, lat);
            chk("b_write_latency", lat, 1);
        end
        @(negedge clk);
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0;
        chk("b2b_first_aok", {31'b0, aok}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d_data_ok", i), {31'b0, dok}, 32'h1);
            chk($sformatf("b2b%0d_addr_ok", i), {31'b0, aok}, 32'h1);
            chk($sformatf("b2b%0d_rdata", i), rdm, exp_b[i]);
            if (i < 3) addr = 32'((i + 1) * 4);
            else       req = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end_data_ok", {31'b0, dok}, 32'h0);

        sel = 2;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            txn(1'b1, 2'd2, 32'(i * 4), model[i], rd, lat);
            if (lat < 2 || lat > 5) chk("rand_init_latency_range", lat, 2);
        end
        for (int t = 0; t < 50; t++) begin
            logic        w;
            logic [1:0]  sz;
            logic [31:0] a, wd, exp;
            logic [3:0]  m;
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 63));
            wd = $urandom;
            exp = model[a[5:2]];
            if (w) begin
                m = lane_mask(sz, a[1:0]);
                for (int l = 0; l < 4; l++)
                    if (m[l]) model[a[5:2]][8*l +: 8] = wd[8*l +: 8];
            end
            txn(w, sz, a, wd, rd, lat);
            checks++;
            if (lat < 2 || lat > 5) begin
                errors++;
                $display("FAIL rand%0d_latency: got %0d required 2..5", t, lat);
            end
            chk($sformatf("rand%0d_rdata", t), rd, exp);
        end
        for (int i = 0; i < 16; i++) begin
            txn(1'b0, 2'd2, 32'(i * 4), 32'h0, rd, lat);
            chk($sformatf("rand_final_word%0d", i), rd, model[i]);
        end

        sel = 3;
        txn(1'b1, 2'd2, 32'h20, 32'hCAFEF00D, rd, lat);
        chk("d_write_latency", lat, 4);
        abandon(1'b0, 32'h20, 32'h0);
        txn(1'b0, 2'd2, 32'h20, 32'h0, rd, lat);
        chk("d_read_after_rst_latency", lat, 4);
        chk("d_read_after_rst_rdata", rd, 32'hCAFEF00D);
        abandon(1'b1, 32'h24, 32'h0BADCAFE);
        txn(1'b0, 2'd2, 32'h24, 32'h0, rd, lat);
        chk("d_abandoned_write_persists", rd, 32'h0BADCAFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
